// File: rtl/store_rmw_seq.sv
// Read-modify-write sequencer that turns sub-word DRAM stores into a word read, merge and write.
// Optional build macro STORE_MISALIGN_TRAP_EN: trap half stores with addr[0]=1 (no write, sticky err).
module store_rmw_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  ex_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_MRG  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_ex_type;
  logic [31:0] r_mem_addr;
  logic        r_mem_we;
  logic [31:0] r_mem_wdata;
  logic        r_done;

  logic        w_start_ok;
  logic        w_is_byte;
  logic [31:0] w_merged;
  logic        w_misalign;
  logic        w_unused;

  // ex_type 00 is not a sub-word store, so it never starts an operation.
  assign w_start_ok = start & (ex_type != 2'b00);
  assign w_is_byte  = r_ex_type[0];
  assign w_unused   = ^wdata[31:16];

  // Little-endian lane merge; bit0 of ex_type wins when both bits are set.
  always_comb begin
    w_merged = mem_rdata;
    if (w_is_byte) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic r_err;

  assign w_misalign = ~r_ex_type[0] & r_ex_type[1] & r_addr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_MRG && w_misalign) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_misalign = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'd0;
      r_wdata     <= 16'd0;
      r_ex_type   <= 2'd0;
      r_mem_addr  <= 32'd0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'd0;
      r_done      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_addr     <= addr;
            r_wdata    <= wdata[15:0];
            r_ex_type  <= ex_type;
            r_mem_addr <= {addr[31:2], 2'b00};
            r_state    <= S_RD;
          end
        end
        S_RD: begin
          r_state <= S_MRG;
        end
        S_MRG: begin
          // Outputs registered here are what the memory sees during WR.
          r_mem_wdata <= w_merged;
          r_mem_we    <= ~w_misalign;
          r_done      <= 1'b1;
          r_state     <= S_WR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall     = (r_state == S_IDLE) ? w_start_ok : 1'b1;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_store_rmw_seq.sv
// Directed bench for store_rmw_seq: byte/half merges, back-to-back, resets, ex_type 00, misaligned half.
module tb_store_rmw_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  ex_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_MRG  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  store_rmw_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ex_type   (ex_type),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ex_type = 2'b00; addr = 32'hFFFF_FFFF;
    wdata = 32'hFFFF_FFFF; mem_rdata = 32'hFFFF_FFFF;
    next(); next();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_addr, mem_wdata} !== 64'd0) begin
      errors++; $display("FAIL reset_data: got addr=%h wdata=%h required 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({mem_we, done, stall, err, dbg_state} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got we/done/stall/err/state=%b required 000000",
                         {mem_we, done, stall, err, dbg_state});
    end
    next();
  endtask

  // addr=0x1002 byte 0xAB over 0x11223344
  task automatic test_byte();
    start = 1'b1; ex_type = 2'b01; addr = 32'h0000_1002; wdata = 32'h0000_00AB;
    mem_rdata = 32'h1122_3344;
    @(negedge clk);
    checks++;
    if ({stall, mem_we, dbg_state} !== {1'b1, 1'b0, S_IDLE}) begin
      errors++; $display("FAIL byte_cycN: got stall/we/state=%b required 1000", {stall, mem_we, dbg_state});
    end
    next(); start = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_state, mem_we, stall} !== {S_RD, 1'b0, 1'b1} || mem_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL byte_rd: got state/we/stall=%b addr=%h required 0101 00001000",
                         {dbg_state, mem_we, stall}, mem_addr);
    end
    next();
    @(negedge clk);
    checks++;
    if ({dbg_state, mem_we, stall} !== {S_MRG, 1'b0, 1'b1}) begin
      errors++; $display("FAIL byte_mrg: got state/we/stall=%b required 1001", {dbg_state, mem_we, stall});
    end
    next();
    @(negedge clk);
    checks++;
    if ({mem_we, done, stall} !== 3'b111 || mem_addr !== 32'h0000_1000 || mem_wdata !== 32'h11AB_3344) begin
      errors++; $display("FAIL byte_wr: got we/done/stall=%b addr=%h wdata=%h required 111 00001000 11ab3344",
                         {mem_we, done, stall}, mem_addr, mem_wdata);
    end
    next();
    @(negedge clk);
    checks++;
    if ({dbg_state, mem_we, done, stall} !== {S_IDLE, 3'b000}) begin
      errors++; $display("FAIL byte_end: got state/we/done/stall=%b required 00000",
                         {dbg_state, mem_we, done, stall});
    end
  endtask

  // addr=0x2002 half 0xBEEF over 0xDEADC0DE; count stall and done cycles
  task automatic test_half_high();
    int stall_cnt;
    int done_cnt;
    logic [31:0] seen;
    stall_cnt = 0; done_cnt = 0; seen = 32'd0;
    next();
    start = 1'b1; ex_type = 2'b10; addr = 32'h0000_2002; wdata = 32'h1234_BEEF;
    mem_rdata = 32'hDEAD_C0DE;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) start = 1'b0;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) done_cnt++;
      if (mem_we) seen = mem_wdata;
      next();
    end
    checks++;
    if (seen !== 32'hBEEF_C0DE) begin
      errors++; $display("FAIL half_hi_data: got %h required beefc0de", seen);
    end
    checks++;
    if (stall_cnt != 4) begin
      errors++; $display("FAIL half_hi_stall: got %0d cycles required 4", stall_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL half_hi_done: got %0d cycles required 1", done_cnt);
    end
  endtask

  // ex_type=11 behaves as byte: addr 0x5001 byte 0x77 over 0x11223344
  task automatic test_byte_ex11();
    logic [31:0] seen;
    int we_cnt;
    seen = 32'd0; we_cnt = 0;
    start = 1'b1; ex_type = 2'b11; addr = 32'h0000_5001; wdata = 32'hFFFF_FF77;
    mem_rdata = 32'h1122_3344;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) start = 1'b0;
      @(negedge clk);
      if (mem_we) begin we_cnt++; seen = mem_wdata; end
      next();
    end
    checks++;
    if (we_cnt != 1 || seen !== 32'h1122_7744) begin
      errors++; $display("FAIL byte_ex11: got writes=%0d data=%h required 1 11227744", we_cnt, seen);
    end
  endtask

  // start held high: writes at N+3 and N+7, inputs changed mid-op do not disturb the first write
  task automatic test_back_to_back();
    int we_cnt;
    we_cnt = 0;
    start = 1'b1; ex_type = 2'b01; addr = 32'h0000_3000; wdata = 32'h0000_005A;
    mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin addr = 32'h0000_3003; wdata = 32'h0000_00C3; end
      if (k == 5) start = 1'b0;
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (k == 2) begin
        checks++;
        if (dbg_state !== S_MRG) begin
          errors++; $display("FAIL b2b_no_restart: got state=%0d required 2", dbg_state);
        end
      end
      if (k == 3) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0000_3000 || mem_wdata !== 32'hFFFF_FF5A) begin
          errors++; $display("FAIL b2b_first: got we=%b addr=%h data=%h required 1 00003000 ffffff5a",
                             mem_we, mem_addr, mem_wdata);
        end
      end
      if (k == 4) begin
        checks++;
        if ({dbg_state, stall, mem_we} !== {S_IDLE, 1'b1, 1'b0}) begin
          errors++; $display("FAIL b2b_gap: got state/stall/we=%b required 0010", {dbg_state, stall, mem_we});
        end
      end
      if (k == 7) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0000_3000 || mem_wdata !== 32'hC3FF_FFFF) begin
          errors++; $display("FAIL b2b_second: got we=%b addr=%h data=%h required 1 00003000 c3ffffff",
                             mem_we, mem_addr, mem_wdata);
        end
      end
      next();
    end
    checks++;
    if (we_cnt != 2) begin
      errors++; $display("FAIL b2b_count: got %0d writes required 2", we_cnt);
    end
  endtask

  // rst in MRG aborts; rst together with start discards the start
  task automatic test_reset_mid();
    int we_cnt;
    we_cnt = 0;
    start = 1'b1; ex_type = 2'b01; addr = 32'h0000_1000; wdata = 32'h0000_0099;
    mem_rdata = 32'h5555_5555;
    next(); start = 1'b0;
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dbg_state, mem_we, done, stall, err} !== 6'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL rst_mrg: got state/we/done/stall/err=%b addr=%h data=%h required all 0",
                         {dbg_state, mem_we, done, stall, err}, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 4; k++) begin
      next();
      @(negedge clk);
      if (mem_we) we_cnt++;
    end
    checks++;
    if (we_cnt != 0) begin
      errors++; $display("FAIL rst_mrg_nowrite: got %0d writes required 0", we_cnt);
    end
    next();
    rst = 1'b1; start = 1'b1;
    next();
    rst = 1'b0; start = 1'b0;
    next();
    @(negedge clk);
    checks++;
    if ({dbg_state, stall, mem_we} !== 4'b0) begin
      errors++; $display("FAIL rst_with_start: got state/stall/we=%b required 0000", {dbg_state, stall, mem_we});
    end
    next();
  endtask

  task automatic test_ex_none();
    int we_cnt;
    int busy;
    we_cnt = 0; busy = 0;
    start = 1'b1; ex_type = 2'b00; addr = 32'h0000_6000; wdata = 32'h0000_0011;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL ex00_stall: got %b required 0", stall);
    end
    for (int k = 0; k < 5; k++) begin
      next();
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (dbg_state !== S_IDLE || stall !== 1'b0) busy++;
    end
    checks++;
    if (we_cnt != 0 || busy != 0) begin
      errors++; $display("FAIL ex00_idle: got writes=%0d busy_cycles=%0d required 0 0", we_cnt, busy);
    end
    start = 1'b0;
    next();
  endtask

  // half to 0x4001: trapped with the macro, lane [15:0] written without it
  task automatic test_misalign();
    start = 1'b1; ex_type = 2'b10; addr = 32'h0000_4001; wdata = 32'h0000_1234;
    mem_rdata = 32'hAAAA_AAAA;
    next(); start = 1'b0;
    next(); next();
    @(negedge clk);
`ifdef STORE_MISALIGN_TRAP_EN
    checks++;
    if ({mem_we, done, err} !== 3'b011) begin
      errors++; $display("FAIL misalign_trap: got we/done/err=%b required 011", {mem_we, done, err});
    end
    next(); next();
    @(negedge clk);
    checks++;
    if ({err, mem_we} !== 2'b10) begin
      errors++; $display("FAIL misalign_sticky: got err/we=%b required 10", {err, mem_we});
    end
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL misalign_clear: got err=%b required 0", err);
    end
`else
    checks++;
    if ({mem_we, done, err} !== 3'b110 || mem_wdata !== 32'hAAAA_1234) begin
      errors++; $display("FAIL misalign_plain: got we/done/err=%b data=%h required 110 aaaa1234",
                         {mem_we, done, err}, mem_wdata);
    end
`endif
    next();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ex_type = 2'b00; addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0;
    #1;
    test_reset();
    test_byte();
    test_half_high();
    test_byte_ex11();
    test_back_to_back();
    test_reset_mid();
    test_ex_none();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_rmw_seq.md
STORE_RMW_SEQ -- requirements
Module: store_rmw_seq

Interface
REQ-001 SHALL have a single clock and a reset that is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL provide start input 1: store needing a split, driven from decoder inst_div qualified by instruction valid.
REQ-003 SHALL provide ex_type input 2: {half, byte}, from decoder DRAM_EX_TYPE.
REQ-004 SHALL provide addr input 32: byte address of the store (ALU result).
REQ-005 SHALL provide wdata input 32: rs2 value; the low byte or low half is used.
REQ-006 SHALL provide mem_rdata input 32: DRAM read data, valid one cycle after mem_addr is presented.
REQ-007 SHALL provide mem_addr output 32: word-aligned DRAM address, with bits [1:0] always 0.
REQ-008 SHALL provide mem_we output 1: DRAM write enable.
REQ-009 SHALL provide mem_wdata output 32: merged word to write.
REQ-010 SHALL provide stall output 1: holds PC and upstream registers.
REQ-011 SHALL provide done output 1: one-cycle pulse when the write is issued.
REQ-012 SHALL provide err output 1: sticky misaligned-half flag, present only under the configuration macro and tied to 0 otherwise.

Function
REQ-013 SHALL implement the states IDLE, RD, MRG, WR, each encoded in 2 bits.
REQ-014 SHALL, in IDLE with start=1, latch addr, wdata and ex_type on the clock edge and go to RD.
REQ-015 SHALL ignore start in RD, MRG and WR; no queueing.
REQ-016 SHALL, in RD, drive mem_addr={addr[31:2],2'b00} with mem_we=0, then go to MRG.
REQ-017 SHALL, in MRG, sample mem_rdata, compute the merged word, register it into mem_wdata, then go to WR.
REQ-018 SHALL, in WR, drive mem_we=1 and done=1 with mem_addr unchanged, then return to IDLE.
REQ-019 SHALL register mem_addr, mem_we, mem_wdata and done, with no combinational path from start to the memory outputs.
REQ-020 SHALL produce the following cycle timing: start sampled at edge N, RD during N+1, MRG during N+2, WR during N+3, IDLE at N+4; total latency 4 cycles.
REQ-021 SHALL drive stall = (state==IDLE & start) | (state!=IDLE), which is combinational and high from cycle N through N+3.
REQ-022 SHALL merge bytes as: byte lane = addr[1:0]; the lane takes wdata[7:0]; the other 3 lanes keep mem_rdata (little-endian).
REQ-023 SHALL merge halves as: lane = addr[1]; 0 selects bits [15:0], 1 selects bits [31:16]; the lane takes wdata[15:0]; the other half keeps mem_rdata.
REQ-024 SHALL treat ex_type=2'b11 as byte, with bit0 taking priority.
REQ-025 SHALL, on start with ex_type=2'b00, stay in IDLE with stall=0 and perform no memory access.
REQ-026 SHALL, without the configuration macro, ignore addr[0] on half stores.
REQ-027 SHALL allow back-to-back operations: start high in the IDLE cycle directly after WR begins a new operation.
REQ-028 SHALL drive mem_we=0 in every state except WR.

Reset
REQ-029 SHALL, when rst=1 at an edge, set state=IDLE and mem_addr=0, mem_we=0, mem_wdata=0, done=0, err=0, and clear the latched fields.
REQ-030 SHALL give rst priority over start in the same cycle, with the start discarded.
REQ-031 SHALL abort any operation when rst arrives mid-operation (RD/MRG/WR) with no write issued after that edge; stall=0 from the next cycle.

Configuration
REQ-032 SHALL use the macro STORE_MISALIGN_TRAP_EN to control misaligned-half handling.
REQ-033 SHALL, when STORE_MISALIGN_TRAP_EN is defined, handle a half store with addr[0]=1 as follows: enter RD and MRG normally; in WR set mem_we=0 and done=1, and set err=1 until rst.
REQ-034 SHALL, when STORE_MISALIGN_TRAP_EN is undefined, tie err to 0 and perform no misalignment check; addr[0] is ignored.

Verification
REQ-035 SHALL cover a byte store: addr=0x1002, wdata=0xAB, ex_type=01, mem_rdata=0x11223344 -> mem_addr=0x1000 and mem_wdata=0x11AB3344 with mem_we=1 in cycle N+3.
REQ-036 SHALL cover a high-half store: addr=0x2002, wdata=0xBEEF, ex_type=10, mem_rdata=0xDEADC0DE -> mem_wdata=0xBEEFC0DE, done pulse exactly one cycle, stall high for 4 cycles.
REQ-037 SHALL cover back-to-back stores: byte to 0x3000, then start held in the following IDLE -> two writes 4 cycles apart; start held high during an operation does not restart it.
REQ-038 SHALL cover reset during MRG: rst=1 in cycle N+2 -> mem_we stays 0 in all cycles after, state=IDLE, all outputs 0.
REQ-039 SHALL cover ex_type=00 with start=1 -> stall=0, no mem_we, state stays IDLE.
REQ-040 SHALL cover a misaligned half with the macro defined: addr=0x4001, ex_type=10 -> no write, done=1 at N+3, err=1 and holds; without the macro, the same stimulus writes lane [15:0].
